// File: rtl/seq_divider_if.sv
// Bundle of operand, result and status signals for seq_divider.
//
// Handshake: start is a request that is taken on a rising clock edge only
// while the divider is idle or showing a result (IDLE or DONE); a start seen
// in any other state is ignored, not queued. Operands are sampled on that
// accepting edge only. done is a one-cycle completion strobe, and quotient,
// remainder and div_by_zero stay valid from done until the next accepted start.
interface seq_divider_if;
    logic       start;
    logic [9:0] dividend;
    logic [4:0] divisor;
    logic [9:0] quotient;
    logic [4:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic [1:0] dbg_state;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, dbg_state
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, dbg_state
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: 10-bit dividend / 5-bit divisor, one quotient
// bit per clock, MSB first. Divide-by-zero short-circuits to an all-ones
// quotient with a flag. dbg_state mirrors the FSM state for observation.
module seq_divider (
    input  logic          clock,
    input  logic          reset,
    seq_divider_if.slave  dif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       accept;

    logic [3:0] cnt;
    // Partial remainder stays below the divisor between steps, so five bits
    // hold it; the shifted value p_sh is the full 6-bit working remainder.
    logic [4:0] p;
    // Holds the unconsumed dividend bits at the top and collects quotient
    // bits at the bottom as the iteration proceeds.
    logic [9:0] q;
    logic [4:0] dvsr;

    logic [5:0] p_sh;
    logic [4:0] p_step;
    logic [9:0] q_step;
    logic       last;

    // One restoring step: shift P:Q left, subtract the divisor when it fits.
    always_comb begin
        p_sh   = {p, q[9]};
        q_step = {q[8:0], 1'b0};
        p_step = p_sh[4:0];
        if (p_sh >= {1'b0, dvsr}) begin
            // The difference is below the divisor, so it fits in five bits.
            p_step    = p_sh[4:0] - dvsr;
            q_step[0] = 1'b1;
        end
    end

    assign last = (cnt == 4'd9);

    // Next-state logic and start acceptance.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (dif.start) begin
                    accept    = 1'b1;
                    state_nxt = (dif.divisor == 5'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (dif.start) begin
                    accept    = 1'b1;
                    state_nxt = (dif.divisor == 5'd0) ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset wins over any start on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt             <= 4'd0;
            p               <= 5'd0;
            q               <= 10'd0;
            dvsr            <= 5'd0;
            dif.quotient    <= 10'd0;
            dif.remainder   <= 5'd0;
            dif.div_by_zero <= 1'b0;
        end else if (accept) begin
            if (dif.divisor != 5'd0) begin
                dvsr <= dif.divisor;
                q    <= dif.dividend;
                p    <= 5'd0;
                cnt  <= 4'd0;
            end else begin
                dif.quotient    <= 10'h3FF;
                dif.remainder   <= 5'd0;
                dif.div_by_zero <= 1'b1;
            end
        end else if (state == S_RUN) begin
            p   <= p_step;
            q   <= q_step;
            cnt <= cnt + 4'd1;
            if (last) begin
                cnt             <= 4'd0;
                dif.quotient    <= q_step;
                dif.remainder   <= p_step;
                dif.div_by_zero <= 1'b0;
            end
        end
    end

    assign dif.busy      = (state == S_RUN);
    assign dif.done      = (state == S_DONE);
    assign dif.dbg_state = state;

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider, the inverse of the 5x5 Wallace tree multiplier in the rec03 datapath. Divides a 10-bit unsigned dividend by a 5-bit unsigned divisor and produces a 10-bit quotient and a 5-bit remainder. Any 10-bit product from the multiplier, divided by a non-zero 5-bit factor, returns the other factor with remainder 0. Resolves one quotient bit per clock under a start/done handshake.

## Interface

- No parameters. Widths are fixed at 10/5 to match the multiplier.
- clock  input  1  single system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clock.
- start  input  1  request; accepted only in IDLE or DONE.
- dividend  input  10  unsigned; captured on the accepting edge.
- divisor  input  5  unsigned; captured on the accepting edge.
- quotient  output  10  result; valid from done high until the next accepted start.
- remainder  output  5  result; same validity as quotient.
- busy  output  1  high while in RUN.
- done  output  1  high for exactly one cycle (DONE state).
- div_by_zero  output  1  high with done when the captured divisor was 0; held with the results.

## Operation

- States: IDLE, RUN, DONE.
- IDLE with start=1:
  - Divisor non-zero: capture the operands, clear the 6-bit partial remainder P, set the 4-bit counter to 0, go to RUN.
  - Divisor = 0: go straight to DONE with quotient=10'h3FF, remainder=0, div_by_zero=1.
- RUN, each cycle:
  - Shift P:Q left by one, bringing in the next dividend bit, MSB first.
  - If P >= {1'b0,divisor}: P = P - divisor and the new quotient LSB = 1. Otherwise the LSB = 0.
  - P needs 6 bits. P < divisor holds after every step, so the final P fits in 5 bits.
- RUN exit: after the 10th iteration (counter = 9), write quotient/remainder and go to DONE.
- DONE:
  - done=1 for this one cycle.
  - start=1 is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- start in RUN is ignored. The operation in flight completes unaffected.
- Operand inputs are don't-care except on the accepting edge.
- quotient, remainder and div_by_zero change only when a result is written or on reset. They hold their values through IDLE.
- Reset (at any time, including mid-RUN):
  - State goes to IDLE and the counter to 0.
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
  - An aborted operation never asserts done.

## Timing

- E0 is the posedge where start is accepted.
- Non-zero divisor:
  - busy=1 from E0 through E10.
  - Iterations run at edges E1..E10.
  - Results and done=1 appear after E10. done falls after E11.
  - Latency is 11 cycles from acceptance to done.
- Zero divisor: done=1 after E0 (latency 1 cycle); busy stays 0.
- Back-to-back: start held high with done=1 is accepted at that edge. done drops and busy rises in the same cycle. Sustained throughput is one operation per 11 cycles.
- busy and done are never high together.
- Reset asserted on the same edge as start takes priority; start is ignored.

## Test plan

- Multiplier inverse: 36/2 -> quotient=18, remainder=0, done exactly 11 cycles after acceptance. 54/3 -> 18 r 0.
- Extremes: 1023/1 -> 1023 r 0. 1000/31 -> 32 r 8. 0/7 -> 0 r 0. 5/9 -> 0 r 5. Check div_by_zero=0 on every one.
- Divide by zero: 100/0 -> done one cycle after start, quotient=10'h3FF, remainder=0, div_by_zero=1, busy never high. A following 36/2 clears div_by_zero.
- Protocol:
  - start pulsed mid-RUN with different operands -> ignored; the original result is produced.
  - start held in DONE -> second operation starts immediately; the first result is visible for exactly one done cycle.
  - Results hold in IDLE for at least 20 cycles.
- Reset mid-RUN (cycle 5) -> next cycle busy=0, done=0, all outputs 0. No done pulse ever follows. A subsequent 54/3 -> 18 r 0.
- Randomized sweep: at least 1000 random dividend/divisor pairs, divisor != 0 -> quotient*divisor + remainder == dividend and remainder < divisor, checked against a behavioural model.
